// File: rtl/exc_redirect_pkg.sv
// Shared constants and FSM encoding for the exception-redirect block.
package exc_redirect_pkg;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_DRAIN    = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;
endpackage

// File: rtl/exc_redirect_fetch_txn_counter.sv
// Tracks in-flight fetch transactions and how many stale responses must still be dropped.
module fetch_txn_counter #(
  parameter int MAX_OUTSTANDING = 2,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic addr_ok,
  input  logic data_ok,
  input  logic snapshot,
  output logic discard,
  output logic cnt_zero
);
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard_cnt;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_disc_left;
  logic          w_dec;

  assign discard     = data_ok & (r_discard_cnt != '0);
  assign w_dec       = data_ok & (r_discard_cnt == '0);
  assign w_disc_left = r_discard_cnt - CW'(discard);
  assign w_out_next  = r_outstanding + CW'(addr_ok) - CW'(w_dec);
  // Reports the count as it will be after this cycle's discard, so the FSM can leave DRAIN on time.
  assign cnt_zero    = (w_disc_left == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_outstanding <= '0;
      r_discard_cnt <= '0;
    end else if (snapshot) begin
      // Everything still in flight becomes stale; stack it on top of any pending discards.
      r_outstanding <= '0;
      r_discard_cnt <= w_out_next + w_disc_left;
    end else begin
      r_outstanding <= w_out_next;
      r_discard_cnt <= w_disc_left;
    end
  end
endmodule

// File: rtl/exc_redirect.sv
// Converts committed exceptions/erets into a flush pulse and a held fetch redirect, dropping stale fetches.
module exc_redirect
  import exc_redirect_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEF,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_oc,
  input  logic        ec_eret,
  input  logic [31:0] cp0_epc,
  input  logic        inst_req,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        redirect_ack,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        inst_discard,
  output logic        if_hold
);
  state_t      r_state;
  logic        r_flush;
  logic        r_redirect_valid;
  logic        r_if_hold;
  logic [31:0] r_redirect_pc;

  logic        w_ev;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_cnt_zero;

  assign w_ev     = exc_oc | ec_eret;
  assign w_target = exc_oc ? EXC_VECTOR : cp0_epc;
  // Requests issued while IF is held violate the protocol and are not counted.
  assign w_accept = inst_req & inst_addr_ok & ~r_if_hold;

  fetch_txn_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .addr_ok  (w_accept),
    .data_ok  (inst_data_ok),
    .snapshot (w_ev),
    .discard  (inst_discard),
    .cnt_zero (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_if_hold        <= 1'b0;
      r_redirect_pc    <= EXC_VECTOR;
    end else if (w_ev) begin
      r_state          <= S_FLUSH;
      r_flush          <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_if_hold        <= 1'b1;
      r_redirect_pc    <= w_target;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        S_FLUSH, S_DRAIN: begin
          if (w_cnt_zero) begin
            r_state          <= S_REDIRECT;
            r_redirect_valid <= 1'b1;
            r_if_hold        <= 1'b0;
          end else begin
            r_state          <= S_DRAIN;
            r_redirect_valid <= 1'b0;
            r_if_hold        <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (redirect_ack) begin
            r_state          <= S_IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_redirect_valid <= 1'b0;
          r_if_hold        <= 1'b0;
        end
      endcase
    end
  end

  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign if_hold        = r_if_hold;
endmodule

// File: tb/tb_exc_redirect.sv
// Directed bench for exc_redirect: flush timing, redirect hand-off, stale-response discard.
module tb_exc_redirect;
  logic        clk = 1'b0;
  logic        resetn;
  logic        exc_oc, ec_eret;
  logic [31:0] cp0_epc;
  logic        inst_req, inst_addr_ok, inst_data_ok, redirect_ack;
  logic        flush, redirect_valid, inst_discard, if_hold;
  logic [31:0] redirect_pc;

  int nv   = 0;
  int nerr = 0;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  always #5 clk = ~clk;

  exc_redirect dut (
    .clk            (clk),
    .resetn         (resetn),
    .exc_oc         (exc_oc),
    .ec_eret        (ec_eret),
    .cp0_epc        (cp0_epc),
    .inst_req       (inst_req),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .redirect_ack   (redirect_ack),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_discard   (inst_discard),
    .if_hold        (if_hold)
  );

  // Counter overflow/underflow guard: either counter wrapping shows up as a value above 2.
  always @(negedge clk) begin
    if (resetn === 1'b1 && (dut.u_cnt.r_outstanding > 2'd2 || dut.u_cnt.r_discard_cnt > 2'd2)) begin
      nerr++;
      $display("FAIL cnt_range outstanding=%0d discard_cnt=%0d required <=2",
               dut.u_cnt.r_outstanding, dut.u_cnt.r_discard_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exc_oc = 0; ec_eret = 0; inst_req = 0; inst_addr_ok = 0;
    inst_data_ok = 0; redirect_ack = 0;
  endtask

  task automatic test_reset();
    resetn = 0; clr(); cp0_epc = 32'h0;
    cyc(); cyc();
    nv++; if (flush !== 1'b0) begin nerr++; $display("FAIL rst_flush got %b want 0", flush); end
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL rst_rv got %b want 0", redirect_valid); end
    nv++; if (if_hold !== 1'b0) begin nerr++; $display("FAIL rst_hold got %b want 0", if_hold); end
    nv++; if (inst_discard !== 1'b0) begin nerr++; $display("FAIL rst_discard got %b want 0", inst_discard); end
    nv++; if (redirect_pc !== VEC) begin nerr++; $display("FAIL rst_pc got %h want %h", redirect_pc, VEC); end
    resetn = 1;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_idle_exc();
    exc_oc = 1; cyc(); clr();
    nv++; if (flush !== 1'b1) begin nerr++; $display("FAIL idle_flush got %b want 1", flush); end
    nv++; if (if_hold !== 1'b1) begin nerr++; $display("FAIL idle_hold got %b want 1", if_hold); end
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL idle_rv0 got %b want 0", redirect_valid); end
    cyc();
    nv++; if (flush !== 1'b0) begin nerr++; $display("FAIL idle_flush_once got %b want 0", flush); end
    nv++; if (redirect_valid !== 1'b1) begin nerr++; $display("FAIL idle_rv got %b want 1", redirect_valid); end
    nv++; if (redirect_pc !== VEC) begin nerr++; $display("FAIL idle_pc got %h want %h", redirect_pc, VEC); end
    nv++; if (if_hold !== 1'b0) begin nerr++; $display("FAIL idle_hold_rel got %b want 0", if_hold); end
    cyc();
    nv++; if (redirect_valid !== 1'b1) begin nerr++; $display("FAIL idle_rv_held got %b want 1", redirect_valid); end
    redirect_ack = 1; cyc(); clr();
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL idle_ack got %b want 0", redirect_valid); end
    $display("test_idle_exc done");
  endtask

  task automatic test_eret();
    cp0_epc = 32'h8000_1234; ec_eret = 1; cyc(); clr();
    cp0_epc = 32'h0;
    nv++; if (flush !== 1'b1) begin nerr++; $display("FAIL eret_flush got %b want 1", flush); end
    nv++; if (redirect_pc !== 32'h8000_1234) begin nerr++; $display("FAIL eret_pc got %h want 80001234", redirect_pc); end
    cyc();
    nv++; if (redirect_valid !== 1'b1) begin nerr++; $display("FAIL eret_rv got %b want 1", redirect_valid); end
    nv++; if (redirect_pc !== 32'h8000_1234) begin nerr++; $display("FAIL eret_pc_hold got %h want 80001234", redirect_pc); end
    redirect_ack = 1; cyc(); clr();
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL eret_ack got %b want 0", redirect_valid); end
    $display("test_eret done");
  endtask

  task automatic test_drain();
    inst_req = 1; inst_addr_ok = 1; cyc(); cyc(); clr();
    exc_oc = 1; cyc(); clr();
    nv++; if (flush !== 1'b1) begin nerr++; $display("FAIL drain_flush got %b want 1", flush); end
    cyc();
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL drain_rv0 got %b want 0", redirect_valid); end
    nv++; if (if_hold !== 1'b1) begin nerr++; $display("FAIL drain_hold got %b want 1", if_hold); end
    inst_data_ok = 1; #1;
    nv++; if (inst_discard !== 1'b1) begin nerr++; $display("FAIL drain_disc1 got %b want 1", inst_discard); end
    cyc();
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL drain_rv1 got %b want 0", redirect_valid); end
    nv++; if (inst_discard !== 1'b1) begin nerr++; $display("FAIL drain_disc2 got %b want 1", inst_discard); end
    cyc(); clr();
    nv++; if (redirect_valid !== 1'b1) begin nerr++; $display("FAIL drain_rv_rise got %b want 1", redirect_valid); end
    inst_req = 1; inst_addr_ok = 1; cyc(); clr();
    inst_data_ok = 1; redirect_ack = 1; #1;
    nv++; if (inst_discard !== 1'b0) begin nerr++; $display("FAIL drain_disc3 got %b want 0", inst_discard); end
    cyc(); clr();
    $display("test_drain done");
  endtask

  task automatic test_same_cycle();
    inst_req = 1; inst_addr_ok = 1; cyc();
    inst_data_ok = 1; exc_oc = 1; #1;
    nv++; if (inst_discard !== 1'b0) begin nerr++; $display("FAIL same_disc_ev got %b want 0", inst_discard); end
    cyc(); clr();
    nv++; if (flush !== 1'b1) begin nerr++; $display("FAIL same_flush got %b want 1", flush); end
    cyc();
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL same_rv0 got %b want 0", redirect_valid); end
    inst_data_ok = 1; #1;
    nv++; if (inst_discard !== 1'b1) begin nerr++; $display("FAIL same_disc1 got %b want 1", inst_discard); end
    cyc(); clr();
    nv++; if (redirect_valid !== 1'b1) begin nerr++; $display("FAIL same_rv got %b want 1", redirect_valid); end
    inst_req = 1; inst_addr_ok = 1; cyc(); clr();
    inst_data_ok = 1; redirect_ack = 1; #1;
    nv++; if (inst_discard !== 1'b0) begin nerr++; $display("FAIL same_disc2 got %b want 0", inst_discard); end
    cyc(); clr();
    $display("test_same_cycle done");
  endtask

  task automatic test_priority();
    cp0_epc = 32'h8000_5555; exc_oc = 1; ec_eret = 1; cyc(); clr();
    nv++; if (redirect_pc !== VEC) begin nerr++; $display("FAIL prio_pc got %h want %h", redirect_pc, VEC); end
    cyc();
    nv++; if (redirect_valid !== 1'b1) begin nerr++; $display("FAIL prio_rv got %b want 1", redirect_valid); end
    cp0_epc = 32'h8000_0100; ec_eret = 1; cyc(); clr();
    nv++; if (flush !== 1'b1) begin nerr++; $display("FAIL ovw_flush got %b want 1", flush); end
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL ovw_rv0 got %b want 0", redirect_valid); end
    nv++; if (redirect_pc !== 32'h8000_0100) begin nerr++; $display("FAIL ovw_pc got %h want 80000100", redirect_pc); end
    cyc();
    nv++; if (redirect_valid !== 1'b1) begin nerr++; $display("FAIL ovw_rv got %b want 1", redirect_valid); end
    redirect_ack = 1; cyc(); clr();
    $display("test_priority done");
  endtask

  task automatic test_reset_drain();
    inst_req = 1; inst_addr_ok = 1; cyc(); cyc(); clr();
    cp0_epc = 32'h8000_2000; ec_eret = 1; cyc(); clr();
    cyc();
    nv++; if (if_hold !== 1'b1) begin nerr++; $display("FAIL rd_hold got %b want 1", if_hold); end
    resetn = 0; cyc(); resetn = 1;
    nv++; if (if_hold !== 1'b0) begin nerr++; $display("FAIL rd_hold0 got %b want 0", if_hold); end
    nv++; if (redirect_valid !== 1'b0) begin nerr++; $display("FAIL rd_rv got %b want 0", redirect_valid); end
    nv++; if (flush !== 1'b0) begin nerr++; $display("FAIL rd_flush got %b want 0", flush); end
    nv++; if (redirect_pc !== VEC) begin nerr++; $display("FAIL rd_pc got %h want %h", redirect_pc, VEC); end
    inst_req = 1; inst_addr_ok = 1; cyc(); clr();
    inst_data_ok = 1; #1;
    nv++; if (inst_discard !== 1'b0) begin nerr++; $display("FAIL rd_disc got %b want 0", inst_discard); end
    cyc(); clr();
    $display("test_reset_drain done");
  endtask

  initial begin
    test_reset();
    test_idle_exc();
    test_eret();
    test_drain();
    test_same_cycle();
    test_priority();
    test_reset_drain();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
